uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder_pkg.sv | 15 +
 rtl/uart_byte_fifo.sv | 69 ++++++
 rtl/uart_tx_feeder.sv | 108 ++++++++++
 tb/tb_uart_tx_feeder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// uart_tx_feeder_pkg
//   Shared definitions for the UART transmit feeder: default FIFO geometry
//   and the handshake FSM state encoding.
package uart_tx_feeder_pkg;

  localparam int FEEDER_DEPTH  = 16;
  localparam int FEEDER_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARM       = 2'd1,
    ST_WAIT_DONE = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo
//   Circular byte FIFO with separate read/write pointers wrapping modulo DEPTH.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     wr_en, wr_data  write strobe and byte; ignored while full
//     rd_en           pop the head byte; ignored while empty
//     rd_data         head byte (combinational read at rd_ptr)
//     count           bytes held, full = count==DEPTH, empty = count==0
module uart_byte_fifo
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH  = FEEDER_DEPTH,
  parameter int ADDR_W = FEEDER_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_ok, rd_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    // A simultaneous write and pop moves both pointers but leaves count alone.
    if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
    else if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Queues bytes and hands them one at a time to a UART transmitter using a
//   ready / bits_ok handshake.
//   Ports:
//     sys_clk, rst_n  clock, asynchronous active-low reset
//     wr_en, wr_data  byte write strobe and data
//     clr_ovf         clears the sticky overflow flag
//     tx_bits_ok      transmitter idle/stop, able to take a byte
//     tx_ready        byte presented; transmitter starts on its rising edge
//     tx_data         presented byte, stable while tx_ready is high
//     full, empty     FIFO status
//     count           queued bytes, including the one presented
//     overflow        sticky: a write arrived while full and was dropped
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH  = FEEDER_DEPTH,
  parameter int ADDR_W = FEEDER_ADDR_W
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              clr_ovf,
  input  logic              tx_bits_ok,
  output logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  feeder_state_e state_q;
  logic          tx_ready_q;
  logic [7:0]    tx_data_q;
  logic          overflow_q, overflow_d;
  logic          pop;
  logic [7:0]    head_byte;

  // The transmitter dropping tx_bits_ok while armed means it took the byte.
  assign pop = (state_q == ST_ARM) & ~tx_bits_ok;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head_byte),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // A dropped write wins over a clear in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    if (wr_en && full) overflow_d = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  // tx_data is loaded only when entering ARM, so it cannot move while
  // tx_ready is high. WAIT_DONE plus IDLE give at least two low cycles.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tx_ready_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty && tx_bits_ok) begin
            tx_data_q  <= head_byte;
            tx_ready_q <= 1'b1;
            state_q    <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (!tx_bits_ok) begin
            tx_ready_q <= 1'b0;
            state_q    <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_bits_ok) state_q <= ST_IDLE;
        end
        default: begin
          tx_ready_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
//   Directed bench for uart_tx_feeder: a table of fill/overflow vectors plus
//   hand-written sequences for single byte, burst, simultaneous write/pop with
//   wrap-around, reset while armed, and random transmitter latency.
module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              sys_clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              clr_ovf;
  logic              tx_bits_ok;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;

  uart_tx_feeder #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .clr_ovf    (clr_ovf),
    .tx_bits_ok (tx_bits_ok),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  // Transmitter model state
  bit         model_en = 1'b0;
  bit         lat_rand = 1'b0;
  int         acc_delay = 1;
  int         lat_fix = 1;
  int         busy = 0;
  int         acc_cnt = 0;
  logic [7:0] rx_q[$];

  // Handshake monitor state
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         low_run = 100;
  int         stab_err = 0;
  int         gap_err = 0;

  typedef struct {
    int         reps;
    logic       wr;
    logic [7:0] data;
    logic       clr;
    int         exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One clock: sample just after the edge, run the monitor, then the model.
  task automatic step();
    @(posedge sys_clk);
    #1;
    if (tx_ready && prev_ready && (tx_data !== prev_data)) stab_err++;
    if (tx_ready && !prev_ready && low_run < 2) gap_err++;
    if (tx_ready) low_run = 0;
    else          low_run++;
    prev_ready = tx_ready;
    prev_data  = tx_data;
    if (model_en) begin
      if (busy > 0) begin
        busy--;
        if (busy == 0) tx_bits_ok = 1'b1;
      end else if (tx_ready && tx_bits_ok) begin
        acc_cnt++;
        if (acc_cnt >= acc_delay) begin
          rx_q.push_back(tx_data);
          acc_cnt    = 0;
          busy       = lat_rand ? int'($urandom_range(200, 1)) : lat_fix;
          tx_bits_ok = 1'b0;
        end
      end
    end
  endtask

  task automatic start_model(input int acc, input int lat, input bit rnd);
    model_en   = 1'b1;
    acc_delay  = acc;
    lat_fix    = lat;
    lat_rand   = rnd;
    busy       = 0;
    acc_cnt    = 0;
    tx_bits_ok = 1'b1;
    rx_q.delete();
  endtask

  task automatic drain(input int n, input int budget);
    int cyc = 0;
    while (!(rx_q.size() >= n && busy == 0 && tx_bits_ok) && cyc < budget) begin
      step();
      cyc++;
    end
    if (cyc >= budget) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d bytes, expected %0d", rx_q.size(), n);
    end
    step();
    step();
  endtask

  task automatic check_rx(input string name, input int base, input int n);
    check({name, "_len"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check($sformatf("%s[%0d]", name, i), int'(rx_q[i]), (base + i) & 8'hFF);
  endtask

  initial begin
    int rises;

    tbl[0] = '{1,  1'b0, 8'h00, 1'b0, 0,  1'b0, 1'b1, 1'b0};
    tbl[1] = '{1,  1'b1, 8'h20, 1'b0, 1,  1'b0, 1'b0, 1'b0};
    tbl[2] = '{14, 1'b1, 8'h21, 1'b0, 15, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1,  1'b1, 8'h2F, 1'b0, 16, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1,  1'b1, 8'hEE, 1'b0, 16, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1,  1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1,  1'b1, 8'hEF, 1'b1, 16, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{2,  1'b0, 8'h00, 1'b0, 16, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1,  1'b0, 8'h00, 1'b1, 16, 1'b1, 1'b0, 1'b0};

    wr_en      = 1'b0;
    wr_data    = 8'h00;
    clr_ovf    = 1'b0;
    tx_bits_ok = 1'b0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #20;
    check("rst_tx_ready", int'(tx_ready), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_overflow", int'(overflow), 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    step();

    // Single byte: tx_ready two cycles after the write, byte held until taken
    start_model(3, 10, 1'b0);
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    check("single_ready_early", int'(tx_ready), 0);
    check("single_count", int'(count), 1);
    step();
    check("single_ready_rise", int'(tx_ready), 1);
    check("single_data", int'(tx_data), 8'hA5);
    drain(1, 200);
    check_rx("single_rx", 8'hA5, 1);
    check("single_empty", int'(empty), 1);
    check("single_ready_low", int'(tx_ready), 0);

    // Fill / overflow / clear table, transmitter held busy
    model_en   = 1'b0;
    tx_bits_ok = 1'b0;
    foreach (tbl[k]) begin
      for (int r = 0; r < tbl[k].reps; r++) begin
        wr_en   = tbl[k].wr;
        wr_data = tbl[k].data + 8'(r);
        clr_ovf = tbl[k].clr;
        step();
      end
      wr_en   = 1'b0;
      clr_ovf = 1'b0;
      check($sformatf("tbl%0d_count", k), int'(count), tbl[k].exp_count);
      check($sformatf("tbl%0d_full", k), int'(full), int'(tbl[k].exp_full));
      check($sformatf("tbl%0d_empty", k), int'(empty), int'(tbl[k].exp_empty));
      check($sformatf("tbl%0d_ovf", k), int'(overflow), int'(tbl[k].exp_ovf));
      check($sformatf("tbl%0d_ready", k), int'(tx_ready), 0);
    end
    start_model(1, 2, 1'b0);
    drain(16, 1000);
    check_rx("tbl_rx", 8'h20, 16);

    // Burst of 16 with a slow-to-accept transmitter
    start_model(16, 10, 1'b0);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      step();
    end
    wr_en = 1'b0;
    check("burst_full", int'(full), 1);
    check("burst_count", int'(count), 16);
    drain(16, 2000);
    check_rx("burst_rx", 8'h01, 16);
    check("burst_ovf", int'(overflow), 0);
    check("burst_empty", int'(empty), 1);

    // Write coinciding with a pop at count=5, then wrap past address 15
    model_en   = 1'b0;
    tx_bits_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      step();
    end
    wr_en = 1'b0;
    check("simul_count_pre", int'(count), 5);
    tx_bits_ok = 1'b1;
    step();
    check("simul_ready", int'(tx_ready), 1);
    check("simul_data", int'(tx_data), 8'h40);
    tx_bits_ok = 1'b0;
    wr_en = 1'b1; wr_data = 8'h45;
    step();
    wr_en = 1'b0;
    check("simul_count", int'(count), 5);
    check("simul_ready_low", int'(tx_ready), 0);
    start_model(1, 3, 1'b0);
    for (int i = 0; i < 11; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h46 + i);
      step();
    end
    wr_en = 1'b0;
    drain(16, 1000);
    check_rx("wrap_rx", 8'h41, 16);
    check("wrap_ovf", int'(overflow), 0);

    // Random transmitter latency
    start_model(2, 1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      step();
    end
    wr_en = 1'b0;
    drain(10, 5000);
    check_rx("rand_rx", 8'h60, 10);
    check("stable_while_ready", stab_err, 0);
    check("ready_low_gap", gap_err, 0);

    // Reset while armed with three bytes queued
    model_en   = 1'b0;
    tx_bits_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h70 + i);
      step();
    end
    wr_en = 1'b0;
    tx_bits_ok = 1'b1;
    step();
    check("arm_ready", int'(tx_ready), 1);
    check("arm_count", int'(count), 3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", int'(tx_ready), 0);
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_empty", int'(empty), 1);
    check("mid_rst_data", int'(tx_data), 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_ready) rises++;
    end
    check("post_rst_no_tx", rises, 0);
    check("post_rst_count", int'(count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
